// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single port of the 256x16 data memory between requester 0
//   (CPU load/store) and requester 1 (loader/debug). Each transaction runs
//   IDLE -> ACCESS -> DONE, three cycles, with a one-cycle ack pulse in DONE.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req/we/addr/wdata 0,1 requester inputs, req held until ack
//   ack0/ack1             one-cycle completion pulse
//   rdata0/rdata1         last read result per port
//   busy                  high in ACCESS and DONE
//   grant                 port currently or last served
//   mem_addr/data/we      drive the memory addr/data/MemWrite
//   mem_out               combinational memory read of mem_addr
//
// Configuration
//   ARB_ROUND_ROBIN_EN    defined: a tie goes to the port not last granted.
//                         undefined: port 0 always wins a tie.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          grant,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  input  logic [DW-1:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic          win;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic          lat_we;

  // Winner selection, only meaningful in IDLE with at least one request.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = ~grant;
`else
      win = 1'b0;
`endif
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req0 || req1) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b1;   // lets port 0 take the first tie after reset
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (req0 || req1)) begin
        grant    <= win;
        lat_addr <= win ? addr1  : addr0;
        lat_data <= win ? wdata1 : wdata0;
        lat_we   <= win ? we1    : we0;
      end
      if (state == ACCESS && !lat_we) begin
        if (grant) rdata1 <= mem_out;
        else       rdata0 <= mem_out;
      end
    end
  end

  // The memory is not reset, so a write in ACCESS still lands on a reset
  // edge; mem_we therefore is not gated by rst. Acks are, so a reset in
  // DONE swallows the pending completion.
  assign mem_addr = lat_addr;
  assign mem_data = lat_data;
  assign mem_we   = (state == ACCESS) && lat_we;
  assign busy     = (state != IDLE);
  assign ack0     = (state == DONE) && !grant && !rst;
  assign ack1     = (state == DONE) &&  grant && !rst;

endmodule
